// File: rtl/rf_writeback_pkg.sv
// Shared types and sizing for the register-file write-back slice.
package rf_writeback_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned AW         = 5;
  localparam int unsigned STARVE_MAX = 3;

  typedef logic [AW-1:0] RegAddr;

  typedef struct packed {
    logic            valid;
    RegAddr          rd;
    logic [XLEN-1:0] data;
  } WbReq;

  typedef struct packed {
    logic            we;
    RegAddr          waddr;
    logic [XLEN-1:0] wdata;
  } RegFileWrite;

  // One-hot scoreboard mask for a register; x0 never maps to a bit.
  function automatic logic [NREG-1:0] reg_bit(input RegAddr a);
    return (NREG'(1) << a) & ~NREG'(1);
  endfunction

endpackage

// File: rtl/rf_writeback_if.sv
// Issue, result-handshake, register-file write and hazard signals of rf_writeback.
interface rf_writeback_if;
  import rf_writeback_pkg::*;

  logic            issue_valid;
  RegAddr          issue_rd;
  logic            alu_valid;
  RegAddr          alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  RegAddr          lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            rf_we;
  RegAddr          rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  RegAddr          rs1_addr;
  RegAddr          rs2_addr;
  logic            rs1_hazard;
  logic            rs2_hazard;
  logic [NREG-1:0] busy;

  modport master (
    output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data, rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata,
    input  rs1_hazard, rs2_hazard, busy
  );

  modport slave (
    input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data, rs1_addr, rs2_addr,
    output alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata,
    output rs1_hazard, rs2_hazard, busy
  );

endinterface

// File: rtl/wb_arbiter.sv
// ALU/LSU write-port arbiter: ALU priority with a starvation escape for the LSU.
module wb_arbiter
  import rf_writeback_pkg::*;
#(
  parameter int unsigned StarveMax = STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_ready,
  output logic lsu_ready,
  output logic grant_alu,
  output logic grant_lsu
);

  localparam int unsigned CntW = $clog2(StarveMax + 1);

  logic [CntW-1:0] starve_q, starve_d;
  logic            lsu_wins;

  assign lsu_wins  = lsu_valid && (!alu_valid || (starve_q == CntW'(StarveMax)));
  assign grant_lsu = lsu_wins;
  assign grant_alu = alu_valid && !lsu_wins;
  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  always_comb begin
    starve_d = starve_q;
    if (!lsu_valid || grant_lsu) begin
      starve_d = '0;
    end else if (starve_q != CntW'(StarveMax)) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-back: merges ALU/LSU results onto one write port and
// tracks outstanding writes to report read-after-write hazards to decode.
module rf_writeback
  import rf_writeback_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  rf_writeback_if.slave bus
);

  logic            grant_alu, grant_lsu;
  WbReq            acc;
  RegFileWrite     wr_q, wr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_mask, clr_mask;

  wb_arbiter #(
    .StarveMax (STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (bus.alu_valid),
    .lsu_valid (bus.lsu_valid),
    .alu_ready (bus.alu_ready),
    .lsu_ready (bus.lsu_ready),
    .grant_alu (grant_alu),
    .grant_lsu (grant_lsu)
  );

  always_comb begin
    acc = '0;
    if (grant_lsu) begin
      acc = '{valid: 1'b1, rd: bus.lsu_rd, data: bus.lsu_data};
    end else if (grant_alu) begin
      acc = '{valid: 1'b1, rd: bus.alu_rd, data: bus.alu_data};
    end
  end

  // Writes to x0 are accepted upstream but never reach the register file.
  always_comb begin
    wr_d    = wr_q;
    wr_d.we = 1'b0;
    if (acc.valid) begin
      wr_d.we    = (acc.rd != '0);
      wr_d.waddr = acc.rd;
      wr_d.wdata = acc.data;
    end
  end

  // A same-cycle issue to the retiring register wins: the newer writer owns it.
  always_comb begin
    set_mask = bus.issue_valid ? reg_bit(bus.issue_rd) : '0;
    clr_mask = acc.valid ? reg_bit(acc.rd) : '0;
    busy_d   = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      busy_q <= '0;
    end else begin
      wr_q   <= wr_d;
      busy_q <= busy_d;
    end
  end

  // The write-cycle term covers the gap between busy clearing and the RF update.
  always_comb begin
    bus.rs1_hazard = (bus.rs1_addr != '0) &&
                     (busy_q[bus.rs1_addr] || (wr_q.we && (wr_q.waddr == bus.rs1_addr)));
    bus.rs2_hazard = (bus.rs2_addr != '0) &&
                     (busy_q[bus.rs2_addr] || (wr_q.we && (wr_q.waddr == bus.rs2_addr)));
  end

  assign bus.rf_we    = wr_q.we;
  assign bus.rf_waddr = wr_q.waddr;
  assign bus.rf_wdata = wr_q.wdata;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed scenarios plus random traffic
// compared against a behavioural model of arbitration, write-back and scoreboard.
module tb_rf_writeback;
  import rf_writeback_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rf_writeback_if bus ();

  rf_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_busy;
  int          m_cnt;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          lsu_grants;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_haz(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return m_busy[a] || (m_we && (m_waddr == a));
  endfunction

  task automatic model_reset();
    m_busy  = '0;
    m_cnt   = 0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic set_idle();
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.alu_valid   = 1'b0; bus.alu_rd   = '0; bus.alu_data = '0;
    bus.lsu_valid   = 1'b0; bus.lsu_rd   = '0; bus.lsu_data = '0;
    bus.rs1_addr    = '0;   bus.rs2_addr = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'(m_we));
    if (m_we) begin
      chk({tag, "_rf_waddr"}, 32'(bus.rf_waddr), 32'(m_waddr));
      chk({tag, "_rf_wdata"}, bus.rf_wdata, m_wdata);
    end
    chk({tag, "_busy"}, bus.busy, m_busy);
  endtask

  // One clock cycle: apply inputs, check mid-cycle, then advance the model at the edge.
  task automatic cycle(input logic iv, input logic [4:0] ird,
                       input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic [4:0] r1, input logic [4:0] r2);
    logic       lsu_win, a_acc, l_acc, acc;
    logic [4:0] rd;
    logic [31:0] d;
    bus.issue_valid = iv; bus.issue_rd = ird;
    bus.alu_valid   = av; bus.alu_rd   = ard; bus.alu_data = adat;
    bus.lsu_valid   = lv; bus.lsu_rd   = lrd; bus.lsu_data = ldat;
    bus.rs1_addr    = r1; bus.rs2_addr = r2;
    #4;
    lsu_win = lv && (!av || (m_cnt == int'(STARVE_MAX)));
    a_acc   = av && !lsu_win;
    l_acc   = lsu_win;
    chk("alu_ready", 32'(bus.alu_ready), 32'(a_acc));
    chk("lsu_ready", 32'(bus.lsu_ready), 32'(l_acc));
    if (bus.lsu_ready === 1'b1) lsu_grants++;
    check_regs("cyc");
    chk("rs1_hazard", 32'(bus.rs1_hazard), 32'(exp_haz(r1)));
    chk("rs2_hazard", 32'(bus.rs2_hazard), 32'(exp_haz(r2)));
    @(posedge clk);
    #1;
    acc = a_acc || l_acc;
    rd  = l_acc ? lrd : ard;
    d   = l_acc ? ldat : adat;
    m_we = acc && (rd != 5'd0);
    if (acc) begin
      m_waddr = rd;
      m_wdata = d;
      if (rd != 5'd0) m_busy[rd] = 1'b0;
    end
    if (iv && (ird != 5'd0)) m_busy[ird] = 1'b1;
    if (!lv || l_acc) m_cnt = 0;
    else if (m_cnt < int'(STARVE_MAX)) m_cnt = m_cnt + 1;
  endtask

  initial begin
    logic [31:0] ra, rl;
    set_idle();
    model_reset();
    lsu_grants = 0;

    // Reset state
    #3;
    check_regs("reset");
    chk("reset_haz1", 32'(bus.rs1_hazard), 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU result with LSU idle: one-cycle write latency
    cycle(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("t1_we", 32'(bus.rf_we), 32'd1);
    chk("t1_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("t1_wdata", bus.rf_wdata, 32'hDEADBEEF);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_we_drop", 32'(bus.rf_we), 32'd0);

    // Both sources valid for five cycles: LSU forced through on the fourth
    lsu_grants = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 5'd4, 32'(100 + i), 1, 5'd6, 32'(200 + i), 0, 0);
    end
    chk("t2_lsu_grants", 32'(lsu_grants), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Issue x7, retire it two cycles later, watch the rs1 hazard window
    cycle(1, 5'd7, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    chk("t3_busy7", 32'(bus.busy[7]), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    cycle(0, 0, 1, 5'd7, 32'h0000_0777, 0, 0, 0, 5'd7, 0);
    chk("t3_busy7_clr", 32'(bus.busy[7]), 32'd0);
    chk("t3_haz_we_cycle", 32'(bus.rs1_hazard), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    chk("t3_haz_after", 32'(bus.rs1_hazard), 32'd0);

    // Issue x9 in the same cycle an LSU result for x9 retires: set wins
    cycle(1, 5'd9, 0, 0, 0, 1, 5'd9, 32'h0000_0999, 0, 5'd9);
    chk("t4_busy9", 32'(bus.busy[9]), 32'd1);
    chk("t4_waddr", 32'(bus.rf_waddr), 32'd9);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9);

    // x0 result is accepted but never written
    cycle(0, 0, 1, 5'd0, 32'h0000_1234, 0, 0, 0, 5'd0, 5'd9);
    chk("t5_we", 32'(bus.rf_we), 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rl = $urandom;
      cycle(($urandom_range(0, 2) == 0), 5'($urandom),
            ($urandom_range(0, 3) != 0), 5'($urandom), ra,
            ($urandom_range(0, 2) != 0), 5'($urandom), rl,
            ($urandom_range(0, 1) == 0) ? m_waddr : 5'($urandom), 5'($urandom));
    end

    // Clean reset between phases
    set_idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("reset2");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Build busy=0x0F00 with a write in flight, then reset mid-cycle
    cycle(1, 5'd8, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 5'd10, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 5'd11, 1, 5'd3, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
    set_idle();
    bus.rs1_addr = 5'd8;
    bus.rs2_addr = 5'd3;
    #1;
    chk("t6_pre_busy", bus.busy, 32'h0000_0F00);
    chk("t6_pre_we", 32'(bus.rf_we), 32'd1);
    chk("t6_pre_haz1", 32'(bus.rs1_hazard), 32'd1);
    chk("t6_pre_haz2", 32'(bus.rs2_hazard), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_we", 32'(bus.rf_we), 32'd0);
    chk("t6_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("t6_wdata", bus.rf_wdata, 32'd0);
    chk("t6_busy", bus.busy, 32'd0);
    chk("t6_haz1", 32'(bus.rs1_hazard), 32'd0);
    chk("t6_haz2", 32'(bus.rs2_hazard), 32'd0);
    #1 rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-side controller for the 32x32 register file: merges results from the ALU and the load/store unit onto the single register-file write port (we/waddr/wdata).
- Keeps a per-register pending-write scoreboard and reports read-after-write hazards for the two decode-stage read addresses.
- Sits between execute/memory and the register file; decode consumes the hazard outputs to stall.

Parameters:
- XLEN, 32, data width of results and write data
- NREG, 32, number of architectural registers
- AW, 5, register address width, equal to log2(NREG)
- STARVE_MAX, 3, consecutive LSU losses before the LSU is forced to win arbitration

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode issues an instruction that writes issue_rd
- issue_rd  in  AW  destination register of the issued instruction
- alu_valid  in  1  ALU result available
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- lsu_valid  in  1  load result available
- lsu_rd  in  AW  load destination
- lsu_data  in  XLEN  load result
- lsu_ready  out  1  load result accepted this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- rs1_addr  in  AW  decode source 1
- rs2_addr  in  AW  decode source 2
- rs1_hazard  out  1  rs1 value not yet architecturally valid
- rs2_hazard  out  1  rs2 value not yet architecturally valid
- busy  out  NREG  scoreboard, bit i set means a write to x(i) is outstanding

Behaviour:
- Reset (async assert, sync release): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, starvation counter=0.
- Handshake: a source is accepted when valid && ready. ready is combinational from the valids and the starvation counter. It does not depend on any other state. At most one acceptance per cycle.
- Arbitration: the ALU wins by default.
  - The LSU wins when alu_valid=0, or when the counter equals STARVE_MAX.
  - The loser's ready is 0. ready is 0 for a source whose valid is 0.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, when lsu_valid && !lsu_ready.
  - Clears when the LSU is accepted or when lsu_valid=0.
- Latency: an acceptance in cycle t drives rf_we=1 in cycle t+1, with that cycle's rd and data. The register file updates at the end of t+1. rf_we=0 in any cycle that follows a cycle with no acceptance.
- x0: a result with rd=0 is still accepted (ready=1 by normal arbitration). It produces rf_we=0 and leaves busy unchanged.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - An acceptance with rd!=0 clears busy[rd] at the same edge.
  - Set and clear on the same rd in the same cycle: the set wins, because the newer instruction owns the register.
  - busy[0] is always 0.
  - Decode must not issue to a register that is already busy. If it does, busy stays 1 and nothing is counted.
- Hazards (combinational), for rsN_addr!=0:
  - rsN_hazard = busy[rsN_addr] | (rf_we && rf_waddr==rsN_addr).
  - The second term covers cycle t+1: busy is already cleared but the register file still holds the old value.
  - rsN_addr=0 gives hazard=0.
- Reset mid-operation: the pending rf_we is dropped and all busy bits clear. Upstream units are reset by the same rst_n.

Decomposition:
- Bundle package additions:
  - RegAddr typedef (logic [AW-1:0]).
  - WbReq packed struct {valid, rd, data}.
  - RegFileWrite struct {we, waddr, wdata}, which matches the existing register-file input write fields.
- Sub-module wb_arbiter: the ALU/LSU priority selection, the ready outputs and the starvation counter. Its outputs are grant_alu and grant_lsu.
- The scoreboard, write register and hazard logic stay in rf_writeback.

Test Plan:
- ALU alu_valid=1, rd=5, data=0xDEADBEEF with LSU idle -> alu_ready=1 in cycle t; in t+1 rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; t+2 rf_we=0.
- ALU and LSU both valid for 5 cycles with STARVE_MAX=3 -> ALU accepted in cycles 0-2, LSU in cycle 3, ALU in cycle 4; lsu_ready=1 exactly once; counter clears after the LSU grant.
- Issue rd=7, then ALU result rd=7 two cycles later -> busy[7]=1 until the acceptance edge; rs1_addr=7 keeps rs1_hazard=1 through the rf_we cycle and 0 one cycle after.
- Issue rd=9 in the same cycle as an LSU acceptance for rd=9 -> busy[9]=1 afterwards; rf_we=1 with rf_waddr=9 in the next cycle.
- ALU result with rd=0, data=0x1234 -> alu_ready=1, rf_we stays 0, busy unchanged; rs1_addr=0 gives rs1_hazard=0.
- Assert rst_n=0 mid-cycle while rf_we=1 and busy=0x0000_0F00 -> rf_we, rf_waddr, rf_wdata, busy and both hazards go to 0 immediately, without waiting for a clock edge.
